// File: rtl/music_seq_player.sv
// -----------------------------------------------------------------------------
// music_seq_player
//
// Self-contained tone sequencer for the PMOD amplifier. It steps a beat index
// through an external combinational song table, turns the returned tone (Hz)
// into a variable-duty square wave, and handles play/pause/stop, loop or
// one-shot playback and an optional silent articulation gap at the end of each
// beat.
//
// Ports
//   clk         in   1       system clock
//   reset       in   1       asynchronous, active-high reset
//   start       in   1       pulse: play from beat 0 (IDLE) or resume (PAUSE)
//   pause       in   1       pulse: PLAY->PAUSE, PAUSE->PLAY
//   stop        in   1       pulse: abort to IDLE from any state
//   loop_en     in   1       1 = wrap to beat 0 at song end, 0 = one-shot
//   articulate  in   1       1 = silence the last GAP_CYC cycles of each beat
//   gain_lo     in   1       passed straight through to pmod_2
//   duty        in   DUTY_W  audio high-time fraction = duty / 2^DUTY_W
//   tone        in   32      tone in Hz for the current ibeat; 0 = rest
//   ibeat       out  BEAT_W  current beat index into the song table
//   busy        out  1       high in PLAY or PAUSE
//   done        out  1       one-cycle pulse when a one-shot song completes
//   pmod_1      out  1       registered audio square wave
//   pmod_2      out  1       amplifier gain select
//   pmod_4      out  1       amplifier shutdown_n, high only while busy
// -----------------------------------------------------------------------------
module music_seq_player #(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int BEAT_FREQ = 8,
   parameter int SONG_LEN  = 128,
   parameter int BEAT_W    = 8,
   parameter int DUTY_W    = 10,
   parameter int GAP_CYC   = CLK_FREQ / 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              pause,
   input  logic              stop,
   input  logic              loop_en,
   input  logic              articulate,
   input  logic              gain_lo,
   input  logic [DUTY_W-1:0] duty,
   input  logic [31:0]       tone,
   output logic [BEAT_W-1:0] ibeat,
   output logic              busy,
   output logic              done,
   output logic              pmod_1,
   output logic              pmod_2,
   output logic              pmod_4
);

   localparam int BEAT_CYC = CLK_FREQ / BEAT_FREQ;
   localparam int CNT_W    = (BEAT_CYC > 1) ? $clog2(BEAT_CYC) : 1;

   localparam logic [CNT_W-1:0]  BEAT_LAST = CNT_W'(BEAT_CYC - 1);
   // pmod_1 is registered, so its value lands one count later than the
   // beat count it was computed from; the gap window starts one count early.
   localparam logic [CNT_W-1:0]  GAP_FIRST = CNT_W'(BEAT_CYC - GAP_CYC - 1);
   localparam logic [BEAT_W-1:0] SONG_LAST = BEAT_W'(SONG_LEN - 1);
   localparam logic [31:0]       CLK_HZ    = 32'(CLK_FREQ);
   localparam logic [31:0]       NYQ_HZ    = 32'(CLK_FREQ / 2);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PLAY,
      S_PAUSE,
      S_DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [CNT_W-1:0] beat_cnt;
   logic [31:0]      phase;
   logic [31:0]      period;
   logic [31:0]      hi_time;
   logic             rest;

   logic             beat_end;
   logic             song_end;
   logic             in_gap;
   logic [31:0]      period_calc;
   logic [63:0]      hi_prod;
   logic [31:0]      hi_calc;
   logic             rest_calc;

   assign beat_end = (beat_cnt == BEAT_LAST);
   assign song_end = (state == S_PLAY) && beat_end && (ibeat == SONG_LAST);
   assign in_gap   = articulate && (beat_cnt >= GAP_FIRST) && !beat_end;

   // Tone sampling arithmetic; the divide is guarded against tone == 0.
   assign period_calc = (tone == '0) ? '0 : CLK_HZ / tone;
   assign hi_prod     = 64'(period_calc) * 64'(duty);
   assign hi_calc     = 32'(hi_prod >> DUTY_W);
   assign rest_calc   = (tone == '0) || (tone > NYQ_HZ);

   assign pmod_2 = gain_lo;
   assign pmod_4 = busy;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         // NOTE: clocked state uses non-blocking assignments so every register
         // samples the values from before the edge, regardless of block order.
         state <= state_nxt;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first; a path that
      // forgets to assign one would otherwise infer a latch.
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (!stop && start) state_nxt = S_PLAY;
         end
         S_PLAY: begin
            busy = 1'b1;
            if (stop)                       state_nxt = S_IDLE;
            else if (song_end && !loop_en)  state_nxt = S_DONE;
            else if (pause)                 state_nxt = S_PAUSE;
         end
         S_PAUSE: begin
            busy = 1'b1;
            if (stop)                 state_nxt = S_IDLE;
            else if (pause || start)  state_nxt = S_PLAY;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ibeat    <= '0;
         beat_cnt <= '0;
         phase    <= '0;
         period   <= '0;
         hi_time  <= '0;
         rest     <= 1'b1;
         pmod_1   <= 1'b0;
      end else begin
         // Audio only while PLAY continues. Count 0 of a beat is the tone
         // sampling cycle, where period/phase still belong to the old note.
         pmod_1 <= (state == S_PLAY) && (state_nxt == S_PLAY) && !rest &&
                   (beat_cnt != '0) && (phase < hi_time) && !in_gap;

         if ((state == S_IDLE) || (state_nxt == S_IDLE)) begin
            // Covers entry to PLAY from IDLE as well as stop and song end.
            ibeat    <= '0;
            beat_cnt <= '0;
            phase    <= '0;
         end else if (state == S_PLAY) begin
            if (beat_end) begin
               beat_cnt <= '0;
               ibeat    <= (ibeat == SONG_LAST) ? '0 : ibeat + BEAT_W'(1);
            end else begin
               beat_cnt <= beat_cnt + CNT_W'(1);
            end

            // The table has had a full cycle to answer for the new ibeat
            // (including the first beat after start, and a beat that began
            // while paused), so sample here and restart the note phase.
            if (beat_cnt == '0) begin
               period  <= period_calc;
               hi_time <= hi_calc;
               rest    <= rest_calc;
               phase   <= '0;
            end else if (rest || (phase >= period - 32'd1)) begin
               phase <= '0;
            end else begin
               phase <= phase + 32'd1;
            end
         end
         // PAUSE and DONE hold the counters.
      end
   end

endmodule

// File: tb/tb_music_seq_player.sv
// -----------------------------------------------------------------------------
// tb_music_seq_player
//
// Directed bench for music_seq_player at CLK_FREQ=1000, BEAT_FREQ=10,
// SONG_LEN=4, GAP_CYC=20 (100-cycle beats). A small song table answers ibeat.
// Per-beat expectations (beat index, audio high counts before and inside the
// gap window) are queued when a song is set up and popped as each beat plays.
// -----------------------------------------------------------------------------
module tb_music_seq_player;

   localparam int CLK_FREQ  = 1000;
   localparam int BEAT_FREQ = 10;
   localparam int SONG_LEN  = 4;
   localparam int BEAT_W    = 8;
   localparam int DUTY_W    = 10;
   localparam int GAP_CYC   = 20;
   localparam int BEAT_CYC  = CLK_FREQ / BEAT_FREQ;
   localparam int GAP_START = BEAT_CYC - GAP_CYC;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              pause;
   logic              stop;
   logic              loop_en;
   logic              articulate;
   logic              gain_lo;
   logic [DUTY_W-1:0] duty;
   logic [31:0]       tone;
   logic [BEAT_W-1:0] ibeat;
   logic              busy;
   logic              done;
   logic              pmod_1;
   logic              pmod_2;
   logic              pmod_4;

   logic [31:0]       song [SONG_LEN];

   typedef struct {
      int beat;
      int highs;
      int gap_highs;
   } beat_exp_t;

   beat_exp_t sb[$];
   int        checks = 0;
   int        errors = 0;

   music_seq_player #(
      .CLK_FREQ  (CLK_FREQ),
      .BEAT_FREQ (BEAT_FREQ),
      .SONG_LEN  (SONG_LEN),
      .BEAT_W    (BEAT_W),
      .DUTY_W    (DUTY_W),
      .GAP_CYC   (GAP_CYC)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .pause      (pause),
      .stop       (stop),
      .loop_en    (loop_en),
      .articulate (articulate),
      .gain_lo    (gain_lo),
      .duty       (duty),
      .tone       (tone),
      .ibeat      (ibeat),
      .busy       (busy),
      .done       (done),
      .pmod_1     (pmod_1),
      .pmod_2     (pmod_2),
      .pmod_4     (pmod_4)
   );

   always #5 clk = ~clk;

   // External song table.
   always_comb tone = song[ibeat[1:0]];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Audio high cycles expected in beat positions v_lo..v_hi. A sampled note
   // starts high two cycles into its beat and runs phase = v-2 modulo period.
   function automatic int exp_highs(input int tone_hz, input int duty_v,
                                    input bit art, input int v_lo, input int v_hi);
      int p;
      int h;
      int n;
      n = 0;
      if (tone_hz == 0 || tone_hz > CLK_FREQ / 2) return 0;
      p = CLK_FREQ / tone_hz;
      h = (p * duty_v) >> DUTY_W;
      for (int v = v_lo; v <= v_hi; v++) begin
         if (!(art && v >= GAP_START) && ((v - 2) % p) < h) n++;
      end
      return n;
   endfunction

   task automatic push_song(input int nbeats, input int duty_v, input bit art);
      for (int b = 0; b < nbeats; b++) begin
         beat_exp_t e;
         e.beat      = b % SONG_LEN;
         e.highs     = exp_highs(int'(song[b % SONG_LEN]), duty_v, art, 2, GAP_START - 1);
         e.gap_highs = exp_highs(int'(song[b % SONG_LEN]), duty_v, art, GAP_START, BEAT_CYC - 1);
         sb.push_back(e);
      end
   endtask

   // Called at beat position 0; returns at position 0 of the next beat.
   task automatic measure_beat(input string tag);
      beat_exp_t         e;
      int                hi_cnt   = 0;
      int                gap_cnt  = 0;
      int                slip     = 0;
      int                done_cnt = 0;
      int                idle_cnt = 0;
      logic [BEAT_W-1:0] b0;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd1, 32'd0);
         return;
      end
      e  = sb.pop_front();
      b0 = ibeat;
      for (int v = 0; v < BEAT_CYC; v++) begin
         if (ibeat !== b0) slip++;
         if (done !== 1'b0) done_cnt++;
         if (busy !== 1'b1) idle_cnt++;
         if (v >= 2 && v < GAP_START && pmod_1 === 1'b1) hi_cnt++;
         if (v >= GAP_START && pmod_1 === 1'b1) gap_cnt++;
         tick();
      end
      check({tag, "_ibeat"}, 32'(b0), e.beat);
      check({tag, "_beat_len"}, slip, 0);
      check({tag, "_no_done"}, done_cnt, 0);
      check({tag, "_busy"}, idle_cnt, 0);
      check({tag, "_highs"}, hi_cnt, e.highs);
      check({tag, "_gap_highs"}, gap_cnt, e.gap_highs);
   endtask

   initial begin
      int bad;
      start      = 1'b0;
      pause      = 1'b0;
      stop       = 1'b0;
      loop_en    = 1'b0;
      articulate = 1'b0;
      gain_lo    = 1'b1;
      duty       = 10'd512;
      for (int i = 0; i < SONG_LEN; i++) song[i] = 32'd100;

      // Reset values, before any clock edge.
      reset = 1'b0;
      #1 reset = 1'b1;
      #1;
      check("rst_ibeat", 32'(ibeat), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_pmod1", 32'(pmod_1), 0);
      check("rst_pmod4", 32'(pmod_4), 0);
      check("rst_pmod2_hi", 32'(pmod_2), 1);
      gain_lo = 1'b0;
      #1;
      check("rst_pmod2_lo", 32'(pmod_2), 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) tick();
      check("idle_busy", 32'(busy), 0);

      // 1: one-shot, tone 100 Hz, half duty.
      push_song(4, 512, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t1_busy", 32'(busy), 1);
      check("t1_pmod4", 32'(pmod_4), 1);
      repeat (4) measure_beat("t1");
      check("t1_done", 32'(done), 1);
      check("t1_done_busy", 32'(busy), 0);
      check("t1_done_pmod1", 32'(pmod_1), 0);
      tick();
      check("t1_done_once", 32'(done), 0);
      check("t1_idle_ibeat", 32'(ibeat), 0);
      check("t1_idle_pmod4", 32'(pmod_4), 0);
      repeat (3) tick();

      // 2: loop for 1000 cycles, duty 768.
      loop_en = 1'b1;
      duty    = 10'd768;
      push_song(10, 768, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (10) measure_beat("t2");
      check("t2_still_busy", 32'(busy), 1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("t2_stop_busy", 32'(busy), 0);
      check("t2_stop_ibeat", 32'(ibeat), 0);
      repeat (3) tick();

      // 3: pause at 150, resume with start at 300, beat 1 ends at 350.
      duty = 10'd512;
      push_song(1, 512, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      measure_beat("t3");
      repeat (50) tick();
      check("t3_pre_ibeat", 32'(ibeat), 1);
      pause = 1'b1;
      tick();
      pause = 1'b0;
      bad = 0;
      for (int i = 151; i < 300; i++) begin
         if (ibeat !== 8'd1 || pmod_1 !== 1'b0 || busy !== 1'b1) bad++;
         tick();
      end
      check("t3_paused", bad, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      bad = 0;
      for (int i = 301; i < 350; i++) begin
         if (ibeat !== 8'd1) bad++;
         tick();
      end
      check("t3_resume_hold", bad, 0);
      check("t3_beat2_at_350", 32'(ibeat), 2);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      repeat (3) tick();

      // 4: rests (tone 0, tone above Nyquist) and a different pitch/duty.
      loop_en = 1'b0;
      duty    = 10'd256;
      song[0] = 32'd200;
      song[1] = 32'd100;
      song[2] = 32'd0;
      song[3] = 32'd600;
      push_song(4, 256, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) measure_beat("t4");
      check("t4_done", 32'(done), 1);
      tick();
      repeat (3) tick();

      // 5: articulation gap.
      for (int i = 0; i < SONG_LEN; i++) song[i] = 32'd100;
      duty       = 10'd512;
      articulate = 1'b1;
      push_song(4, 512, 1'b1);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) measure_beat("t5");
      check("t5_done", 32'(done), 1);
      tick();
      articulate = 1'b0;
      repeat (3) tick();

      // 6a: stop and pause together at 250.
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (250) tick();
      check("t6_pre_busy", 32'(busy), 1);
      stop  = 1'b1;
      pause = 1'b1;
      tick();
      stop  = 1'b0;
      pause = 1'b0;
      check("t6_stop_busy", 32'(busy), 0);
      check("t6_stop_ibeat", 32'(ibeat), 0);
      check("t6_stop_done", 32'(done), 0);
      check("t6_stop_pmod1", 32'(pmod_1), 0);
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         if (done !== 1'b0 || busy !== 1'b0) bad++;
         tick();
      end
      check("t6_stays_idle", bad, 0);

      // 6b: asynchronous reset at 120, checked before the next edge.
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (120) tick();
      check("t6_pre_rst_ibeat", 32'(ibeat), 1);
      reset = 1'b1;
      #1;
      check("t6_rst_ibeat", 32'(ibeat), 0);
      check("t6_rst_busy", 32'(busy), 0);
      check("t6_rst_pmod1", 32'(pmod_1), 0);
      check("t6_rst_pmod4", 32'(pmod_4), 0);
      check("t6_rst_done", 32'(done), 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) tick();
      check("t6_post_rst_busy", 32'(busy), 0);

      check("sb_left", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
